// File: rtl/bank_input_packer_pkg.sv
// Shared types for the bank input packer: FSM state and a width helper.
package bank_input_packer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } packer_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_input_packer_if.sv
// Producer stream plus assembled-beat bus of one bank input packer.
interface bank_input_packer_if #(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned NUM_LANES = 4
);

  logic [IN_WIDTH-1:0]                 s_data;
  logic                                s_valid;
  logic                                s_last;
  logic                                s_ready;
  logic [NUM_LANES-1:0][IN_WIDTH-1:0]  out_din;
  logic                                out_valid;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, out_din, out_valid
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, out_din, out_valid
  );

endinterface

// File: rtl/bank_input_packer.sv
// Packs NUM_LANES producer words into one bank-write beat and counts beats
// up to a full matrix load, flagging misplaced s_last markers.
module bank_input_packer
  import bank_input_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned TOTAL_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  bank_input_packer_if.slave    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_last
);

  localparam int unsigned LANE_W = idx_width(NUM_LANES);
  localparam int unsigned BEAT_W = $clog2(TOTAL_DEPTH + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TOTAL_DEPTH - 1);

  packer_state_t                       state_q, state_d;
  logic [LANE_W-1:0]                   lane_idx_q, lane_idx_d;
  logic [BEAT_W-1:0]                   beat_cnt_q, beat_cnt_d;
  logic [NUM_LANES-1:0][IN_WIDTH-1:0]  stage_q, stage_d;
  logic [NUM_LANES-1:0][IN_WIDTH-1:0]  out_din_q, out_din_d;
  logic                                out_valid_q, out_valid_d;
  logic                                s_ready_q, s_ready_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                err_last_q, err_last_d;
  logic                                hs_c;
  logic                                final_word_c;

  // Next-state, staging and beat assembly.
  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    beat_cnt_d   = beat_cnt_q;
    stage_d      = stage_q;
    out_din_d    = out_din_q;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    err_last_d   = err_last_q;
    hs_c         = bus.s_valid & s_ready_q;
    final_word_c = (lane_idx_q == LAST_LANE) && (beat_cnt_q == LAST_BEAT);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          lane_idx_d = '0;
          beat_cnt_d = '0;
          err_last_d = 1'b0;
        end
      end
      FILL: begin
        if (hs_c) begin
          stage_d[lane_idx_q] = bus.s_data;
          // s_last is expected on exactly the last word of the load.
          if (bus.s_last != final_word_c) begin
            err_last_d = 1'b1;
          end
          if (lane_idx_q == LAST_LANE) begin
            out_din_d   = stage_d;
            out_valid_d = 1'b1;
            lane_idx_d  = '0;
            beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
            if (beat_cnt_q == LAST_BEAT) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            lane_idx_d = lane_idx_q + LANE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == FILL);
    busy_d    = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_idx_q  <= '0;
      beat_cnt_q  <= '0;
      stage_q     <= '0;
      out_din_q   <= '0;
      out_valid_q <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      stage_q     <= stage_d;
      out_din_q   <= out_din_d;
      out_valid_q <= out_valid_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_last_q  <= err_last_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.out_din   = out_din_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_last      = err_last_q;

endmodule
